// File: rtl/ifu_fetch.sv
// Instruction fetch unit: holds the PC, fetches one word over an AXI-lite-style
// read channel, hands {inst, pc, snpc} to decode and waits for write-back's next PC.
module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [31:0] instF,
    output logic [31:0] pcF,
    output logic [31:0] snpcF,
    output logic        fetch_err,
    output logic        m_valid,
    input  logic        m_ready,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] dnpc
);

    typedef enum logic [1:0] {REQ, WAIT_R, OUT, WAIT_NPC} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;
    logic        err_q;
    logic        aligned;

    assign aligned = (pc_q[1:0] == 2'b00);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= REQ;
            pc_q    <= RESET_PC;
            inst_q  <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                REQ: begin
                    // A misaligned PC never reaches the bus; it is reported as a faulty bundle.
                    if (!aligned) begin
                        err_q   <= 1'b1;
                        inst_q  <= 32'h0;
                        state_q <= OUT;
                    end else if (arready) begin
                        state_q <= WAIT_R;
                    end
                end
                WAIT_R: begin
                    if (rvalid) begin
                        inst_q  <= rdata;
                        err_q   <= (rresp != 2'b00);
                        state_q <= OUT;
                    end
                end
                OUT: begin
                    if (m_ready) state_q <= WAIT_NPC;
                end
                WAIT_NPC: begin
                    if (s_valid) begin
                        pc_q    <= dnpc;
                        state_q <= REQ;
                    end
                end
                default: state_q <= REQ;
            endcase
        end
    end

    // Handshake strobes come from state alone; reset only masks them during the reset cycle.
    assign arvalid   = !rst && (state_q == REQ) && aligned;
    assign rready    = !rst && (state_q == WAIT_R);
    assign m_valid   = !rst && (state_q == OUT);
    assign s_ready   = !rst && (state_q == WAIT_NPC);

    assign araddr    = pc_q;
    assign instF     = inst_q;
    assign pcF       = pc_q;
    assign snpcF     = pc_q + 32'd4;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: normal turn, backpressure, bus fault, misaligned PC,
// PC wrap with spurious handshakes, and reset in the middle of a read.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] instF;
    logic [31:0] pcF;
    logic [31:0] snpcF;
    logic        fetch_err;
    logic        m_valid;
    logic        m_ready;
    logic        s_valid;
    logic        s_ready;
    logic [31:0] dnpc;

    int errors = 0;
    int checks = 0;

    ifu_fetch #(.RESET_PC(32'h8000_0000)) dut (
        .clk(clk), .rst(rst),
        .araddr(araddr), .arvalid(arvalid), .arready(arready),
        .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready),
        .instF(instF), .pcF(pcF), .snpcF(snpcF), .fetch_err(fetch_err),
        .m_valid(m_valid), .m_ready(m_ready),
        .s_valid(s_valid), .s_ready(s_ready), .dnpc(dnpc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Strobe vector {arvalid, rready, m_valid, s_ready}
    task automatic chk_strb(input string tag, input logic [3:0] exp);
        chk(tag, {28'h0, arvalid, rready, m_valid, s_ready}, {28'h0, exp});
    endtask

    initial begin
        rst = 1'b1; arready = 1'b0; rdata = 32'h0; rresp = 2'b00; rvalid = 1'b0;
        m_ready = 1'b0; s_valid = 1'b0; dnpc = 32'h0;
        step(); step();
        #1;
        chk_strb("reset_strobes", 4'b0000);
        chk("reset_pc", pcF, 32'h8000_0000);
        chk("reset_inst", instF, 32'h0);
        chk("reset_err", {31'h0, fetch_err}, 32'h0);

        // Zero-wait turn; cycle 0 is the first cycle after reset release
        rst = 1'b0; #1;
        chk_strb("c0_strobes", 4'b1000);
        chk("c0_araddr", araddr, 32'h8000_0000);
        arready = 1'b1;
        step();
        chk_strb("c1_strobes", 4'b0100);
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0413;
        step();
        chk_strb("c2_strobes", 4'b0010);
        chk("c2_instF", instF, 32'h0000_0413);
        chk("c2_pcF", pcF, 32'h8000_0000);
        chk("c2_snpcF", snpcF, 32'h8000_0004);
        chk("c2_err", {31'h0, fetch_err}, 32'h0);
        rvalid = 1'b0; m_ready = 1'b1;
        step();
        chk_strb("c3_strobes", 4'b0001);
        m_ready = 1'b0; s_valid = 1'b1; dnpc = 32'h8000_0004;
        step();
        s_valid = 1'b0;
        chk_strb("c4_strobes", 4'b1000);
        chk("c4_araddr", araddr, 32'h8000_0004);

        // Backpressure: 3 AR waits, 2 R waits, 4 decode stalls, 2 NPC waits -> 15-cycle turn
        for (int i = 0; i < 3; i++) begin
            step();
            chk_strb("bp_ar_hold", 4'b1000);
            chk("bp_araddr", araddr, 32'h8000_0004);
        end
        arready = 1'b1;
        step();
        arready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_strb("bp_r_wait", 4'b0100);
            step();
        end
        chk_strb("bp_r_last", 4'b0100);
        rvalid = 1'b1; rdata = 32'h0010_0093;
        step();
        rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk_strb("bp_out_hold", 4'b0010);
            chk("bp_instF", instF, 32'h0010_0093);
            chk("bp_pcF", pcF, 32'h8000_0004);
            step();
        end
        chk_strb("bp_out_last", 4'b0010);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk_strb("bp_npc_wait", 4'b0001);
            step();
        end
        chk_strb("bp_npc_last", 4'b0001);
        s_valid = 1'b1; dnpc = 32'h8000_0008;
        step();
        s_valid = 1'b0;
        chk_strb("bp_turn_done", 4'b1000);
        chk("bp_next_addr", araddr, 32'h8000_0008);

        // Bus fault: data still delivered, error flagged; following fetch is clean
        arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rresp = 2'b10; rdata = 32'hDEAD_BEEF;
        step();
        rvalid = 1'b0; rresp = 2'b00;
        chk_strb("flt_strobes", 4'b0010);
        chk("flt_err", {31'h0, fetch_err}, 32'h1);
        chk("flt_instF", instF, 32'hDEAD_BEEF);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0; s_valid = 1'b1; dnpc = 32'h8000_000C;
        step();
        s_valid = 1'b0;
        chk("flt_next_addr", araddr, 32'h8000_000C);
        arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0013;
        step();
        rvalid = 1'b0;
        chk("clean_err", {31'h0, fetch_err}, 32'h0);
        chk("clean_instF", instF, 32'h0000_0013);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0; s_valid = 1'b1; dnpc = 32'h8000_0002;
        step();
        s_valid = 1'b0;

        // Misaligned PC: no bus request, faulty bundle next cycle
        chk_strb("mis_req_strobes", 4'b0000);
        step();
        chk_strb("mis_out_strobes", 4'b0010);
        chk("mis_err", {31'h0, fetch_err}, 32'h1);
        chk("mis_instF", instF, 32'h0);
        chk("mis_pcF", pcF, 32'h8000_0002);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0; s_valid = 1'b1; dnpc = 32'hFFFF_FFFC;
        step();

        // Wrap, with spurious s_valid / m_ready held through REQ and WAIT_R
        dnpc = 32'h1111_1110; m_ready = 1'b1; arready = 1'b1;
        chk_strb("wrap_req", 4'b1000);
        chk("wrap_araddr", araddr, 32'hFFFF_FFFC);
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'h0000_0073;
        chk_strb("wrap_wait_r", 4'b0100);
        step();
        rvalid = 1'b0; s_valid = 1'b0; m_ready = 1'b0;
        chk_strb("wrap_out", 4'b0010);
        chk("wrap_pcF", pcF, 32'hFFFF_FFFC);
        chk("wrap_snpcF", snpcF, 32'h0000_0000);
        chk("wrap_instF", instF, 32'h0000_0073);
        m_ready = 1'b1;
        step();
        m_ready = 1'b0; s_valid = 1'b1; dnpc = 32'h8000_0010;
        step();
        s_valid = 1'b0;

        // Reset in WAIT_R with rvalid low; a late rvalid afterwards is ignored
        chk("rst_pre_addr", araddr, 32'h8000_0010);
        arready = 1'b1;
        step();
        arready = 1'b0;
        chk_strb("rst_in_wait_r", 4'b0100);
        rst = 1'b1; #1;
        chk_strb("rst_cycle_strobes", 4'b0000);
        step();
        rst = 1'b0; rvalid = 1'b1; rdata = 32'h1234_5678; #1;
        chk_strb("rst_after_req", 4'b1000);
        chk("rst_after_addr", araddr, 32'h8000_0000);
        step();
        rvalid = 1'b0;
        chk_strb("rst_late_rvalid", 4'b1000);
        chk("rst_inst_clear", instF, 32'h0);
        arready = 1'b1;
        step();
        arready = 1'b0; rvalid = 1'b1; rdata = 32'hABCD_EF01;
        step();
        rvalid = 1'b0;
        chk_strb("rst_refetch_out", 4'b0010);
        chk("rst_refetch_inst", instF, 32'hABCD_EF01);
        chk("rst_refetch_pc", pcF, 32'h8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ifu_fetch.md
# ifu_fetch

Instruction fetch unit for the multi-cycle NPC core. It holds the architectural PC and reads one instruction word per turn over a simple AXI-lite-style read channel. It then presents {inst, pc, snpc} to the decode-stage register over a valid/ready handshake. It starts the next fetch only after write-back returns the dynamic next PC over a second valid/ready handshake.

## Interface
- `RESET_PC`, default 32'h80000000, PC loaded on reset.
- `clk` in 1: single clock; all logic on posedge.
- `rst` in 1: synchronous, active-high reset.
- `araddr` out 32: read address, equals `pc`.
- `arvalid` out 1: read address valid.
- `arready` in 1: bus accepts the address.
- `rdata` in 32: read data.
- `rresp` in 2: read response; nonzero means access fault.
- `rvalid` in 1: read data valid.
- `rready` out 1: IFU accepts read data.
- `instF` out 32: fetched instruction.
- `pcF` out 32: PC of `instF`.
- `snpcF` out 32: pcF + 4.
- `fetch_err` out 1: the presented instruction is faulty (misaligned PC or nonzero `rresp`).
- `m_valid` out 1: fetch bundle valid toward decode.
- `m_ready` in 1: decode accepts the bundle.
- `s_valid` in 1: write-back presents the next PC.
- `s_ready` out 1: IFU accepts the next PC.
- `dnpc` in 32: next PC from write-back.

## Operation
- The state machine has four states: REQ, WAIT_R, OUT, WAIT_NPC.
- Registers: `pc`, `inst`, `err`, `state`.
- Reset: `pc`=RESET_PC, `inst`=0, `err`=0, state=REQ.
  - `arvalid`, `rready`, `m_valid` and `s_ready` are 0 during the reset cycle.
  - Fetching begins on the first cycle after reset deasserts.
- REQ:
  - If pc[1:0]==0: `arvalid`=1, `araddr`=pc. On `arready`, go to WAIT_R.
  - If pc[1:0]!=0: no bus request. Set `err`=1 and `inst`=0, then go to OUT next cycle.
- WAIT_R:
  - `rready`=1.
  - On `rvalid`: `inst`<=rdata, `err`<=(rresp!=0), go to OUT.
- OUT:
  - `m_valid`=1; `instF`=inst, `pcF`=pc, `snpcF`=pc+4 (mod 2^32), `fetch_err`=err.
  - Outputs stay stable until `m_ready`; then go to WAIT_NPC.
- WAIT_NPC:
  - `s_ready`=1.
  - On `s_valid`: `pc`<=dnpc, go to REQ.
- Output decoding:
  - `arvalid`, `rready`, `m_valid` and `s_ready` are each decoded from state only, never combinationally from inputs.
  - At most one of them is high in any cycle.
- `instF`, `pcF`, `snpcF` and `fetch_err` are driven from registers in every state. Their values are meaningful only while `m_valid`=1.
- Any fault is reported only through `fetch_err`. The unit never stalls or retries on a fault.

## Timing
- Handshakes complete on the clock edge where valid and ready are both 1.
- `araddr` is held stable while `arvalid`=1. `arvalid` is never withdrawn before `arready`.
- The bus may assert `arready` in the same cycle `arvalid` rises. The transfer then completes that edge.
- `rvalid` or `rdata` appearing outside WAIT_R is ignored. The bus contract forbids this.
- `s_valid` outside WAIT_NPC is ignored; write-back holds it until `s_ready`.
- `m_ready` outside OUT is ignored.
- Minimum turn: REQ → WAIT_R → OUT → WAIT_NPC → REQ, four cycles per instruction with zero-wait bus and handshake partners.
  - Each extra bus wait cycle adds one cycle.
  - Each stalled handshake adds one cycle per stalled cycle.
- A misaligned PC goes REQ → OUT in one cycle, with no bus traffic.
- `dnpc`=pc is legal; the same address is refetched.
- PC wrap: pc=0xFFFFFFFC gives snpcF=0x00000000.
- Reset asserted in any state, including mid-AR or mid-R handshake: the next cycle is in REQ state with `pc`=RESET_PC. No in-flight transfer is completed. The bus slave shares `rst` and clears too.

## Test plan
- Reset release, zero-wait bus (`arready`=1), `rdata`=0x00000413 returned 1 cycle later, `m_ready`=1, `s_valid`=1 with `dnpc`=0x80000004:
  - araddr=0x80000000 on cycle 0.
  - m_valid on cycle 2 with instF=0x00000413, pcF=0x80000000, snpcF=0x80000004.
  - arvalid again on cycle 4 with araddr=0x80000004.
- Backpressure: `arready` low for 3 cycles, `rvalid` delayed 2 cycles, `m_ready` low for 4 cycles, `s_valid` delayed 2 cycles:
  - araddr, instF and pcF stay stable throughout; no duplicate AR handshake.
  - Total turn is 4+3+2+4+2 = 15 cycles.
- `rresp`=2'b10 with `rdata`=0xDEADBEEF: m_valid with fetch_err=1 and instF=0xDEADBEEF.
  - The next fetch after `dnpc` proceeds with fetch_err=0.
- `dnpc`=0x80000002: no arvalid. Next cycle m_valid=1, fetch_err=1, instF=0, pcF=0x80000002.
- Wrap: `dnpc`=0xFFFFFFFC → snpcF=0x00000000.
  - Spurious `s_valid` and `m_ready` pulses during REQ and WAIT_R have no effect.
- Reset pulse while in WAIT_R (`rvalid` low):
  - The next cycle is REQ with araddr=0x80000000; m_valid stays 0.
  - A late `rvalid` with 0x12345678 is ignored.
